// File: rtl/disp_value_sel.sv
// Debug display source selector: debounces two push buttons, cycles through
// PC / instruction / ALU / register-file views and registers the selected word.
module disp_value_sel #(
  parameter int unsigned DB_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_mode_n,
  input  logic        key_idx_n,
  input  logic        freeze,
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic [31:0] alu_res,
  input  logic [31:0] rf_rdata,
  output logic [4:0]  rf_raddr,
  output logic [1:0]  mode,
  output logic [31:0] disp_val
);

  localparam int unsigned CntW = $clog2(DB_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {StPc, StInstr, StAlu, StReg} view_e;

  // Bit 0 is the mode key, bit 1 the index key.
  logic [1:0]           key_raw;
  logic [1:0]           sync1_q, sync2_q;
  logic [1:0]           stable_q, stable_d, stable_prev_q;
  logic [1:0][CntW-1:0] cnt_q, cnt_d;
  logic [1:0]           press;
  logic                 mode_ev, idx_ev;

  view_e       state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [31:0] disp_q, disp_d;

  assign key_raw = {key_idx_n, key_mode_n};

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    for (int k = 0; k < 2; k++) begin
      if (sync2_q[k] != stable_q[k]) begin
        if (cnt_q[k] == CntMax) begin
          stable_d[k] = sync2_q[k];
        end else begin
          cnt_d[k] = cnt_q[k] + CntW'(1);
        end
      end
    end
  end

  // Falling edge of the debounced level; release produces nothing.
  assign press   = stable_prev_q & ~stable_q;
  assign mode_ev = press[0];
  assign idx_ev  = press[1];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (mode_ev) begin
      unique case (state_q)
        StPc:    state_d = StInstr;
        StInstr: state_d = StAlu;
        StAlu:   state_d = StReg;
        StReg:   state_d = StPc;
        default: state_d = StPc;
      endcase
    end else if (idx_ev && state_q == StReg) begin
      idx_d = idx_q + 5'd1;
    end
  end

  always_comb begin
    disp_d = disp_q;
    if (!freeze) begin
      unique case (state_q)
        StPc:    disp_d = pc;
        StInstr: disp_d = instr;
        StAlu:   disp_d = alu_res;
        StReg:   disp_d = rf_rdata;
        default: disp_d = pc;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q       <= 2'b11;
      sync2_q       <= 2'b11;
      stable_q      <= 2'b11;
      stable_prev_q <= 2'b11;
      cnt_q         <= '0;
      state_q       <= StPc;
      idx_q         <= 5'd0;
      disp_q        <= 32'h0000_0000;
    end else begin
      sync1_q       <= key_raw;
      sync2_q       <= sync1_q;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      cnt_q         <= cnt_d;
      state_q       <= state_d;
      idx_q         <= idx_d;
      disp_q        <= disp_d;
    end
  end

  assign mode     = state_q;
  assign rf_raddr = idx_q;
  assign disp_val = disp_q;

endmodule

// File: doc/disp_value_sel.md
# disp_value_sel

Debug display source selector sitting directly upstream of the 32-bit-to-eight-hex-digit seven-segment converter on the board top level. It debounces two raw push buttons and cycles through four views: PC, instruction, ALU result, register file entry. A second button steps the register index. The selected 32-bit value is registered and presented on `disp_val`, which feeds the converter's `in` port. A freeze switch holds the displayed value for inspection.

## Interface
- `DB_CYCLES`, default 500000: consecutive stable cycles required to accept a key level change (10 ms at 50 MHz); legal range ≥ 2.
- `clk` in 1: single system clock; all state updates on its rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `key_mode_n` in 1: raw push button, active-low, asynchronous to `clk`; a press advances the view.
- `key_idx_n` in 1: raw push button, active-low, asynchronous; a press increments the register index in REG view.
- `freeze` in 1: level switch; 1 holds `disp_val`.
- `pc` in 32: current program counter.
- `instr` in 32: current instruction word.
- `alu_res` in 32: current ALU result.
- `rf_rdata` in 32: register file debug read data, combinational from `rf_raddr`.
- `rf_raddr` out 5: registered register-file debug read address (current index).
- `mode` out 2: current view (0 PC, 1 INSTR, 2 ALU, 3 REG).
- `disp_val` out 32: registered value to the hex converter.

## Operation
- **Synchroniser:** each key passes through two flops. Both flops reset to 1 (released).
- **Debouncer, per key:**
  - Keeps a `stable` level (reset 1) and a counter (reset 0) wide enough for `DB_CYCLES`.
  - While the synced level equals `stable`, the counter is cleared.
  - While they differ, the counter increments.
  - When the counter reaches `DB_CYCLES-1` with the levels still differing, `stable` takes the synced level and the counter clears.
  - A glitch shorter than `DB_CYCLES` cycles is ignored.
- **Press event:** a one-cycle pulse in the cycle after `stable` goes 1→0. Release (0→1) generates no event. A key held down gives exactly one event.
- **View FSM:** states PC → INSTR → ALU → REG → PC. It advances one state per mode press event. Reset state is PC.
- **Index counter:** 5 bits, reset 0.
  - Increments on an idx press event only when `mode` is REG; wraps from 31 to 0.
  - Leaving and re-entering REG keeps the index.
  - `rf_raddr` equals the index register.
- **Simultaneous events:** if mode and idx press events occur in the same cycle, the mode advances and the idx event is discarded.
- **Display register:**
  - When `freeze`=0, `disp_val` loads on every edge from the source of the current `mode`: `pc`, `instr`, `alu_res` or `rf_rdata`.
  - When `freeze`=1, it holds. Mode and index still update, so releasing freeze shows the current view.
- **Reset values:** `mode`=0, `rf_raddr`=0, `disp_val`=0x00000000, all debounce state released, no pending events.
- **Reset mid-operation:** reset aborts any debounce in progress. If a key is still held after `rst_n` rises, it counts as a new press after the full sync + debounce latency.

## Timing
- Raw key low from cycle 0, held: press event at cycle 2+`DB_CYCLES`+1 ±1. `mode` updates on the edge closing the event cycle. `disp_val` shows the new view source one edge later.
- Index change → `rf_raddr` same edge as `mode`-style update. `disp_val` reflects `rf_rdata` of the new address one edge later.
- Source change with fixed mode and `freeze`=0: `disp_val` follows with 1-cycle latency.
- `freeze` rising at edge N: the value loaded at edge N is the last one. `freeze` falling: load resumes at the next edge.
- Minimum spacing between accepted presses of one key: 2·`DB_CYCLES` cycles (press + release debounce).

## Test plan
Run with `DB_CYCLES`=4.
- **Reset and passthrough:** reset with `pc`=0x00400000, then release → `disp_val`=0 at reset. `disp_val`=0x00400000 one cycle after reset release; `mode`=0, `rf_raddr`=0.
- **View cycling:** four clean mode presses (low 10 cycles, high 10 cycles) with `instr`=0x8C220004, `alu_res`=0xDEADBEEF, `rf_rdata`=0x12345678 → `disp_val` sequence 0x8C220004, 0xDEADBEEF, 0x12345678, then `pc` again.
- **Glitch rejection:** 3-cycle low pulse on `key_mode_n` → no mode change. A 6-cycle low → exactly one advance.
- **Index wrap:** in REG, 33 idx presses → `rf_raddr` 1…31, 0, 1. Idx presses in PC view leave `rf_raddr` unchanged.
- **Simultaneous presses:** both keys pressed on the same cycle in REG with index 5 → `mode`=0, `rf_raddr`=5.
- **Freeze:** in ALU view, `freeze`=1, then `alu_res` changes and a mode press → `disp_val` held, `mode`=3. `freeze`=0 → `disp_val`=`rf_rdata` next edge.
